uart_tx_fifo_ser: RTL

- Transmit-side consumer of the AXI-lite slave write path.
- Accepts byte writes (write strobe, 32-bit write data, byte strobes) into a parameterised TX FIFO.
- Serialises FIFO entries onto txd as 8N1 frames at a fixed clocks-per-bit rate.
- Returns the full flag that gates the slave's write response.

---
 rtl/uart_tx_fifo_ser.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_ser.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_ser
//
// Transmit side of the UART behind the AXI-lite slave. Byte writes from the
// slave write path are queued in a small TX FIFO, and a serializer drains the
// FIFO onto txd as 8N1 frames (start bit, 8 data bits LSB first, stop bit) at
// a fixed number of aclk cycles per bit. The full flag goes back to the slave
// so that it can hold off its write response.
//
// Ports:
//   aclk      - sole clock
//   areset    - asynchronous, active-high reset
//   wr_en     - single-cycle write strobe from the AXI-lite write path
//   wr_data   - write data; only bits [7:0] carry the byte to send
//   wr_strb   - byte strobes; only bit 0 qualifies a write
//   full      - FIFO holds DEPTH entries
//   empty     - FIFO holds no entries
//   level     - current FIFO occupancy (0..DEPTH)
//   overflow  - one-cycle pulse after a write was dropped on a full FIFO
//   busy      - serializer is in the middle of a frame
//   txd       - serial line, idles high, driven straight from a flop
// -----------------------------------------------------------------------------
module uart_tx_fifo_ser #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_strb,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     busy,
  output logic                     txd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic             wr_req;
  logic             push;
  logic             pop;
  logic             baud_done;

  // The upper data bytes and strobes are part of the bus shape but carry
  // nothing for a byte-wide transmit register.
  logic             unused_bits;
  assign unused_bits = ^{wr_data[31:8], wr_strb[3:1]};

  // Flags are decoded from the registered level, so a write that arrives
  // while full is refused even if the serializer pops on the same edge.
  assign wr_req    = wr_en && wr_strb[0];
  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign push      = wr_req && !full;
  assign pop       = (state == IDLE) && !empty;
  assign baud_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign busy      = (state != IDLE);

  // FIFO storage. Contents are don't-care after reset, so no reset here;
  // only the pointers and level decide what is valid.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data[7:0];
    end
  end

  // FIFO bookkeeping: pointers wrap naturally at DEPTH (power of two), and a
  // push and pop on the same edge leave the level untouched. A refused write
  // raises overflow for exactly the following cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_req && full;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Serializer. txd is registered and updated on the same edge as the state
  // change, so the line value always matches the state being entered. The
  // pop happens in IDLE, which is why back-to-back frames are separated by
  // exactly one idle cycle at txd=1.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // Next data bit is shift[1] because shift is moved right on the same
        // edge that starts the new bit.
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          baud_cnt <= '0;
          txd      <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
